// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter
//  Purpose  : Single-port framebuffer arbiter between the VGA scan-out pixel
//             fetcher (display) and a host port (CPU / drawing engine).
//             At most one RAM access per cycle. Display has priority, with a
//             one-entry pending slot so a displaced display read is delayed by
//             one slot and never dropped. A starvation counter forces a host
//             grant after STARVE_MAX waiting cycles.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             disp_req/addr_i     - display read strobe + address
//             disp_rdata/rvalid_o - display read return (in request order)
//             host_req/we/addr/wdata_i - level host request, held until ack
//             host_ack_o          - one-cycle pulse, request issued to RAM
//             host_rdata/rvalid_o - host read return
//             ram_en/we/addr/wdata_o - registered RAM command
//             ram_rdata_i         - RAM read data, one cycle after ram_en
//  Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // display read port
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_rvalid_o,
  // host port
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_rvalid_o,
  // RAM port
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_MAX);

  // Grant selector for the current arbitration cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PEND = 2'd1,
    GNT_DISP = 2'd2,
    GNT_HOST = 2'd3
  } gnt_e;

  gnt_e              gnt;
  logic              host_ok;
  logic              override;

  logic              pend_v_q,    pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        wait_cnt_q,  wait_cnt_d;
  logic              host_ack_q,  host_ack_d;
  logic              ram_en_q,    ram_en_d;
  logic              ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  // Return tags: stage 0 rides with the RAM command, stage 1 with ram_rdata
  logic              tag0_v_q,    tag0_v_d;
  logic              tag0_host_q, tag0_host_d;
  logic              tag1_v_q;
  logic              tag1_host_q;

  logic              disp_rvalid_q;
  logic [DATA_W-1:0] disp_rdata_q;
  logic              host_rvalid_q;
  logic [DATA_W-1:0] host_rdata_q;

  // --------------------------------------------------------------------------
  // Arbitration and next-state
  // --------------------------------------------------------------------------
  always_comb begin
    // The host is blind during its own ack cycle, so a held request cannot
    // be issued twice.
    host_ok  = host_req_i && !host_ack_q;
    override = host_ok && !pend_v_q && (wait_cnt_q == C_STARVE_MAX);

    gnt         = GNT_NONE;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;

    if (pend_v_q) begin
      // Pending always drains; a new display request takes its place.
      gnt      = GNT_PEND;
      pend_v_d = disp_req_i;
      if (disp_req_i) begin
        pend_addr_d = disp_addr_i;
      end
    end else if (override) begin
      gnt = GNT_HOST;
      if (disp_req_i) begin
        pend_v_d    = 1'b1;
        pend_addr_d = disp_addr_i;
      end
    end else if (disp_req_i) begin
      gnt = GNT_DISP;
    end else if (host_ok) begin
      gnt = GNT_HOST;
    end

    // Starvation counter: cleared on grant or when the host lets go
    if (!host_req_i || (gnt == GNT_HOST)) begin
      wait_cnt_d = 8'd0;
    end else if (host_ok && (wait_cnt_q != C_STARVE_MAX)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // RAM command; address/data hold their last value when idle
    ram_en_d    = (gnt != GNT_NONE);
    ram_we_d    = (gnt == GNT_HOST) && host_we_i;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (gnt)
      GNT_PEND: ram_addr_d = pend_addr_q;
      GNT_DISP: ram_addr_d = disp_addr_i;
      GNT_HOST: begin
        ram_addr_d  = host_addr_i;
        ram_wdata_d = host_wdata_i;
      end
      default: ;
    endcase

    host_ack_d  = (gnt == GNT_HOST);
    tag0_v_d    = ram_en_d && !ram_we_d;
    tag0_host_d = (gnt == GNT_HOST);
  end

  // --------------------------------------------------------------------------
  // State registers and read-return routing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q      <= 1'b0;
      pend_addr_q   <= '0;
      wait_cnt_q    <= 8'd0;
      host_ack_q    <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      tag0_v_q      <= 1'b0;
      tag0_host_q   <= 1'b0;
      tag1_v_q      <= 1'b0;
      tag1_host_q   <= 1'b0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      pend_v_q      <= pend_v_d;
      pend_addr_q   <= pend_addr_d;
      wait_cnt_q    <= wait_cnt_d;
      host_ack_q    <= host_ack_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      tag0_v_q      <= tag0_v_d;
      tag0_host_q   <= tag0_host_d;
      tag1_v_q      <= tag0_v_q;
      tag1_host_q   <= tag0_host_q;
      disp_rvalid_q <= tag1_v_q && !tag1_host_q;
      host_rvalid_q <= tag1_v_q && tag1_host_q;
      if (tag1_v_q && !tag1_host_q) begin
        disp_rdata_q <= ram_rdata_i;
      end
      if (tag1_v_q && tag1_host_q) begin
        host_rdata_q <= ram_rdata_i;
      end
    end
  end

  assign disp_rdata_o  = disp_rdata_q;
  assign disp_rvalid_o = disp_rvalid_q;
  assign host_ack_o    = host_ack_q;
  assign host_rdata_o  = host_rdata_q;
  assign host_rvalid_o = host_rvalid_q;
  assign ram_en_o      = ram_en_q;
  assign ram_we_o      = ram_we_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_wdata_o   = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_arbiter
//  Purpose  : Self-checking bench for vga_fb_arbiter. A behavioural RAM
//             answers the DUT's RAM port; a transaction-level scoreboard
//             predicts display/host return data, ordering and latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 12;
  localparam int STARVE_MAX = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_req_i   (disp_req),
    .disp_addr_i  (disp_addr),
    .disp_rdata_o (disp_rdata),
    .disp_rvalid_o(disp_rvalid),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_ack_o   (host_ack),
    .host_rdata_o (host_rdata),
    .host_rvalid_o(host_rvalid),
    .ram_en_o     (ram_en),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata)
  );

  // Initial framebuffer contents; address 5 holds 0xABC
  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    if (a == 17'h5) return 12'hABC;
    return DATA_W'((32'(a) * 37) + 11);
  endfunction

  // Behavioural synchronous RAM
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  typedef struct { int c; logic [ADDR_W-1:0] a; int lat; } dent_t;
  typedef struct { int c; logic [DATA_W-1:0] d; } hent_t;
  dent_t disp_q[$];
  hent_t host_q[$];
  logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];

  int n_chk = 0, n_pass = 0;
  int ack_cnt = 0, wr_cnt = 0, en_cnt = 0, drv_cnt = 0, hrv_cnt = 0, n_disp = 0;
  int ovr_cyc = 32'h7fff_ffff;
  logic              cur_we = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [DATA_W-1:0] cur_wdata = '0;
  logic              prev_ack = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor, sampled on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack = 1'b0;
    end else begin
      if (ram_en) en_cnt++;
      if (ram_en && ram_we) wr_cnt++;
      if (host_ack) begin
        ack_cnt++;
        check_eq("ack_gap", 32'(prev_ack), 32'd0);
        check_eq("ack_ram_cmd", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, cur_we, cur_addr}));
        if (cur_we) check_eq("ack_ram_wdata", 32'(ram_wdata), 32'(cur_wdata));
      end
      prev_ack = host_ack;
      if (disp_rvalid && host_rvalid) check_eq("rvalid_excl", 32'd1, 32'd0);
      if (disp_rvalid) begin
        drv_cnt++;
        if (disp_q.size() == 0) check_eq("disp_unexpected", 32'd1, 32'd0);
        else begin
          dent_t e;
          int    lat;
          e   = disp_q.pop_front();
          lat = cyc - e.c;
          check_eq("disp_data", 32'(disp_rdata), 32'(pix(e.a)));
          if (e.lat == 0) check_eq("disp_lat_range", 32'(lat >= 3 && lat <= 4), 32'd1);
          else            check_eq("disp_lat", 32'(lat), 32'(e.lat));
        end
      end
      if (host_rvalid) begin
        hrv_cnt++;
        if (host_q.size() == 0) check_eq("host_unexpected", 32'd1, 32'd0);
        else begin
          hent_t h;
          h = host_q.pop_front();
          check_eq("host_rdata", 32'(host_rdata), 32'(h.d));
          check_eq("host_rv_lat", 32'(cyc - h.c), 32'd2);
        end
      end
      if (disp_q.size() > 0 && (cyc - disp_q[0].c) > 4) begin
        check_eq("disp_lost", 32'(cyc - disp_q[0].c), 32'd4);
        void'(disp_q.pop_front());
      end
      if (host_q.size() > 0 && (cyc - host_q[0].c) > 2) begin
        check_eq("host_lost", 32'(cyc - host_q[0].c), 32'd2);
        void'(host_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick;
  endtask

  // exact=1: latency is 3, or 4 once the host override cycle has been reached
  task automatic disp_burst(input logic [ADDR_W-1:0] base, input int n, input bit exact);
    for (int i = 0; i < n; i++) begin
      tick;
      disp_req  = 1'b1;
      disp_addr = base + ADDR_W'(i);
      disp_q.push_back('{c: cyc, a: disp_addr, lat: exact ? ((cyc >= ovr_cyc) ? 4 : 3) : 0});
      n_disp++;
    end
    tick;
    disp_req = 1'b0;
  endtask

  // One host transaction: raise the request, hold until ack, drop next cycle.
  task automatic host_op(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input bit arm_ovr,
                         output int wait_cyc);
    int start;
    tick;
    cur_we = we; cur_addr = a; cur_wdata = wd;
    host_we = we; host_addr = a; host_wdata = wd; host_req = 1'b1;
    start = cyc;
    if (arm_ovr) ovr_cyc = start + STARVE_MAX;
    wait_cyc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (host_ack) begin
        wait_cyc = cyc - start;
        break;
      end
    end
    if (wait_cyc < 0) check_eq("host_ack_timeout", 32'd0, 32'd1);
    else if (we) shadow[a] = wd;
    else host_q.push_back('{c: cyc, d: shadow.exists(a) ? shadow[a] : pix(a)});
    tick;
    host_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w, w2, base_drv, base_ack, base_hrv, base_wr, base_en, base_nd, t_end;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pix(ADDR_W'(i));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ram_cmd",   32'({ram_en, ram_we, ram_addr}), 32'd0);
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check_eq("rst_disp",      32'({disp_rvalid, disp_rdata}), 32'd0);
    check_eq("rst_host",      32'({host_ack, host_rvalid, host_rdata}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle host read of address 5
    base_drv = drv_cnt;
    host_op(1'b0, 17'h5, 12'h000, 1'b0, w);
    check_eq("t1_ack_lat", 32'(w), 32'd1);
    idle(4);
    check_eq("t1_no_disp_rv", 32'(drv_cnt - base_drv), 32'd0);
    check_eq("t1_host_rv", 32'(hrv_cnt), 32'd1);

    // Eight back-to-back display reads, addresses 0..7
    base_drv = drv_cnt;
    disp_burst(17'h0, 8, 1'b1);
    idle(6);
    check_eq("t2_disp_cnt", 32'(drv_cnt - base_drv), 32'd8);

    // Continuous display plus one host write: starvation override
    base_wr = wr_cnt;
    fork
      disp_burst(17'h300, 40, 1'b1);
      begin
        idle(1);
        host_op(1'b1, 17'h100, 12'h0F0, 1'b1, w);
      end
    join
    ovr_cyc = 32'h7fff_ffff;
    idle(8);
    check_eq("t3_ack_wait", 32'(w), 32'(STARVE_MAX + 1));
    check_eq("t3_ram_writes", 32'(wr_cnt - base_wr), 32'd1);
    check_eq("t3_ram_content", 32'(mem[17'h100]), 32'h0F0);
    check_eq("t3_disp_drained", 32'(disp_q.size()), 32'd0);

    // Single host read: one ack, one rvalid over a six-cycle window
    base_ack = ack_cnt; base_hrv = hrv_cnt;
    host_op(1'b0, 17'h1234, 12'h000, 1'b0, w);
    idle(6);
    check_eq("t4_ack_lat", 32'(w), 32'd1);
    check_eq("t4_ack_cnt", 32'(ack_cnt - base_ack), 32'd1);
    check_eq("t4_rv_cnt",  32'(hrv_cnt - base_hrv), 32'd1);

    // Reset with two display reads in flight
    tick; disp_req = 1'b1; disp_addr = 17'h40;
    tick; disp_addr = 17'h41;
    tick; disp_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_ram_cmd",   32'({ram_en, ram_we, ram_addr}), 32'd0);
    check_eq("t5_rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check_eq("t5_rst_disp",      32'({disp_rvalid, disp_rdata}), 32'd0);
    check_eq("t5_rst_host",      32'({host_ack, host_rvalid, host_rdata}), 32'd0);
    tick; rst_n = 1'b1;
    base_drv = drv_cnt;
    idle(8);
    check_eq("t5_no_rv_after_rst", 32'(drv_cnt - base_drv), 32'd0);
    host_op(1'b0, 17'h5, 12'h000, 1'b0, w);
    check_eq("t5_cold_ack_lat", 32'(w), 32'd1);
    disp_burst(17'h7, 1, 1'b1);
    idle(6);

    // Randomised traffic: ~75% display duty, random host reads/writes
    base_en = en_cnt; base_ack = ack_cnt; base_nd = n_disp;
    t_end = cyc + 380;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          tick;
          if ($urandom_range(0, 3) != 0) begin
            disp_req  = 1'b1;
            disp_addr = 17'h1000 + ADDR_W'($urandom_range(0, 4095));
            disp_q.push_back('{c: cyc, a: disp_addr, lat: 0});
            n_disp++;
          end else begin
            disp_req = 1'b0;
          end
        end
        tick;
        disp_req = 1'b0;
      end
      begin
        while (cyc < t_end) begin
          idle($urandom_range(0, 4));
          host_op(1'($urandom_range(0, 1)), 17'h2000 + ADDR_W'($urandom_range(0, 63)),
                  DATA_W'($urandom), 1'b0, w2);
        end
      end
    join
    idle(10);
    check_eq("rnd_disp_drained", 32'(disp_q.size()), 32'd0);
    check_eq("rnd_host_drained", 32'(host_q.size()), 32'd0);
    check_eq("rnd_ram_accesses", 32'(en_cnt - base_en),
             32'((n_disp - base_nd) + (ack_cnt - base_ack)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
